// File: rtl/regfile_param.sv
// Parametrised two-read / one-write register file with registered A/B
// operand outputs, optional hardwired-zero register, same-cycle write
// forwarding, and a sequential engine that clears every register in turn.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] write_data,
  input  logic              clear_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              busy,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  // Depth widened by one bit so the compare works even when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W-1:0] idx;
  logic              wr_commit;
  logic [DATA_W-1:0] rv_a;
  logic [DATA_W-1:0] rv_b;

  function automatic logic addr_valid(input logic [ADDR_W-1:0] x);
    return ({1'b0, x} < DEPTH_EXT);
  endfunction

  // Stored contents as seen by a reader: invalid addresses and the
  // hardwired zero register always read as zero.
  function automatic logic [DATA_W-1:0] base_read(input logic [ADDR_W-1:0] x);
    logic [DATA_W-1:0] v;
    v = '0;
    if (addr_valid(x) && !(ZERO_REG != 0 && x == '0)) begin
      v = regs[x];
    end
    return v;
  endfunction

  // A write only lands while idle, to a valid address, and never to the zero register.
  assign wr_commit = (state == IDLE) && RegWrite && addr_valid(rd) &&
                     !(ZERO_REG != 0 && rd == '0);

  // Operand read values, forwarding the committing write when enabled.
  always_comb begin
    rv_a = base_read(rs);
    rv_b = base_read(rt);
    if (BYPASS != 0 && wr_commit && rd == rs) begin
      rv_a = write_data;
    end
    if (BYPASS != 0 && wr_commit && rd == rt) begin
      rv_b = write_data;
    end
  end

  // Debug port never forwards; it shows only the committed contents.
  assign dbg_data = base_read(dbg_addr);

  // Register array: normal writes while idle, one zeroed entry per cycle while clearing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (state == CLEAR) begin
      regs[idx] <= '0;
    end else if (wr_commit) begin
      regs[rd] <= write_data;
    end
  end

  // Clear sequencer: walks idx from 0 to DEPTH-1, holding busy the whole time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (idx == IDX_LAST) begin
            state <= IDLE;
            idx   <= '0;
            busy  <= 1'b0;
          end else begin
            idx <= idx + IDX_ONE;
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Operand registers refresh every idle cycle and freeze while clearing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      A <= '0;
      B <= '0;
    end else if (state == IDLE) begin
      A <= rv_a;
      B <= rv_b;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: default build plus variants with
// the zero register disabled and with forwarding disabled, all sharing stimulus.
module tb_regfile_param;

  logic        clk;
  logic        reset_n;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        RegWrite;
  logic [31:0] write_data;
  logic        clear_req;
  logic [4:0]  dbg_addr;

  logic [31:0] a_main, b_main, dbg_main;
  logic        busy_main;
  logic [31:0] a_nz, b_nz, dbg_nz;
  logic        busy_nz;
  logic [31:0] a_nb, b_nb, dbg_nb;
  logic        busy_nb;

  int tests_run;
  int tests_failed;
  int busy_cycles;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  regfile_param dut (
    .clk(clk), .reset_n(reset_n), .rs(rs), .rt(rt), .rd(rd),
    .RegWrite(RegWrite), .write_data(write_data), .clear_req(clear_req),
    .dbg_addr(dbg_addr), .A(a_main), .B(b_main), .busy(busy_main),
    .dbg_data(dbg_main)
  );

  regfile_param #(.ZERO_REG(0)) dut_nz (
    .clk(clk), .reset_n(reset_n), .rs(rs), .rt(rt), .rd(rd),
    .RegWrite(RegWrite), .write_data(write_data), .clear_req(clear_req),
    .dbg_addr(dbg_addr), .A(a_nz), .B(b_nz), .busy(busy_nz),
    .dbg_data(dbg_nz)
  );

  regfile_param #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .rs(rs), .rt(rt), .rd(rd),
    .RegWrite(RegWrite), .write_data(write_data), .clear_req(clear_req),
    .dbg_addr(dbg_addr), .A(a_nb), .B(b_nb), .busy(busy_nb),
    .dbg_data(dbg_nb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] fill_val(input int i);
    return 32'(i) * 32'h0101_0101;
  endfunction

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_pop(input logic [31:0] obs);
    exp_t e;
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        tests_failed++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    RegWrite   = 1'b1;
    rd         = addr;
    write_data = data;
    tick();
    RegWrite   = 1'b0;
  endtask

  task automatic check_all_dbg_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      push_exp(tag, 32'h0);
      check_pop(dbg_main);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    rs           = '0;
    rt           = '0;
    rd           = '0;
    RegWrite     = 1'b0;
    write_data   = '0;
    clear_req    = 1'b0;
    dbg_addr     = '0;

    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Asynchronous reset mid-cycle
    write_reg(5'd2, 32'h55);
    write_reg(5'd3, 32'h66);
    rs = 5'd2;
    rt = 5'd3;
    tick();
    push_exp("pre_reset_A", 32'h55);
    check_pop(a_main);
    #2;
    reset_n = 1'b0;
    #1;
    push_exp("reset_A", 32'h0);
    check_pop(a_main);
    push_exp("reset_B", 32'h0);
    check_pop(b_main);
    push_exp("reset_busy", 32'h0);
    check_pop({31'b0, busy_main});
    check_all_dbg_zero("reset_dbg");
    @(negedge clk);
    reset_n = 1'b1;
    rs = '0;
    rt = '0;

    // Basic write then read
    write_reg(5'd2, 32'h00F3_4E5B);
    write_reg(5'd3, 32'h0001_A45F);
    rs = 5'd2;
    rt = 5'd3;
    tick();
    push_exp("rw_A", 32'h00F3_4E5B);
    check_pop(a_main);
    push_exp("rw_B", 32'h0001_A45F);
    check_pop(b_main);

    // Zero register
    rs = 5'd0;
    rt = 5'd0;
    write_reg(5'd0, 32'hFFFF_FFFF);
    tick();
    dbg_addr = 5'd0;
    #1;
    push_exp("zero_dbg_main", 32'h0);
    check_pop(dbg_main);
    push_exp("zero_A_main", 32'h0);
    check_pop(a_main);
    push_exp("nozero_dbg", 32'hFFFF_FFFF);
    check_pop(dbg_nz);
    push_exp("nozero_A", 32'hFFFF_FFFF);
    check_pop(a_nz);

    // Same-cycle write forwarding
    write_reg(5'd5, 32'h11);
    rs         = 5'd5;
    RegWrite   = 1'b1;
    rd         = 5'd5;
    write_data = 32'hABCD;
    tick();
    RegWrite   = 1'b0;
    push_exp("bypass_A", 32'hABCD);
    check_pop(a_main);
    push_exp("nobypass_A_old", 32'h11);
    check_pop(a_nb);
    tick();
    push_exp("nobypass_A_new", 32'hABCD);
    check_pop(a_nb);

    // Bulk clear
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), fill_val(i));
    end
    rs = 5'd2;
    rt = 5'd3;
    tick();
    push_exp("preclear_A", fill_val(2));
    check_pop(a_main);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    busy_cycles = 0;
    while (busy_main === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      RegWrite   = (busy_cycles == 3);
      rd         = 5'd7;
      write_data = 32'hDEAD_BEEF;
      clear_req  = (busy_cycles == 10);
      if (busy_cycles == 5) begin
        rs = 5'd4;
        rt = 5'd4;
      end
      tick();
    end
    RegWrite  = 1'b0;
    clear_req = 1'b0;
    push_exp("clear_busy_cycles", 32'd32);
    check_pop(32'(busy_cycles));
    push_exp("clear_A_hold", fill_val(2));
    check_pop(a_main);
    push_exp("clear_B_hold", fill_val(3));
    check_pop(b_main);
    check_all_dbg_zero("clear_dbg");
    dbg_addr = 5'd0;
    #1;
    push_exp("clear_nozero_r0", 32'h0);
    check_pop(dbg_nz);
    tick();
    push_exp("postclear_A", 32'h0);
    check_pop(a_main);

    // Reset in the middle of a clear
    write_reg(5'd20, 32'h77);
    rs = 5'd20;
    tick();
    push_exp("premid_A", 32'h77);
    check_pop(a_main);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (9) tick();
    push_exp("mid_busy_high", 32'h1);
    check_pop({31'b0, busy_main});
    #2;
    reset_n = 1'b0;
    #1;
    push_exp("mid_reset_busy", 32'h0);
    check_pop({31'b0, busy_main});
    push_exp("mid_reset_A", 32'h0);
    check_pop(a_main);
    check_all_dbg_zero("mid_reset_dbg");
    @(negedge clk);
    reset_n = 1'b1;
    rs = 5'd4;
    write_reg(5'd4, 32'h1234);
    dbg_addr = 5'd4;
    #1;
    push_exp("after_reset_dbg_r4", 32'h1234);
    check_pop(dbg_main);
    push_exp("after_reset_A_r4", 32'h1234);
    check_pop(a_main);
    push_exp("after_reset_busy", 32'h0);
    check_pop({31'b0, busy_main});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
